// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, synchroniser depth and receiver states.
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int IDX_W       = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  function automatic logic is_last_bit(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(DATA_BITS - 1);
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period up-counter: clear forces zero, full wraps it; half/full strobe on terminal counts.
module uart_rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic half,
  output logic full
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    half = (cnt_q == HALF_TC);
    full = (cnt_q == FULL_TC);
    if (clear || full) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, frame FSM, shift register and sticky status flags.
//   state | meaning
//   IDLE  | line high, waiting for a falling edge on rxd_s
//   START | half a bit in, confirm the start bit is still low
//   DATA  | sample one data bit per bit period, LSB first
//   STOP  | sample the stop bit; publish byte or flag framing error
//   BREAK | stop bit was low, wait for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 clrRxDone,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxDone,
  output logic                 frameErr,
  output logic                 overrun,
  output logic                 rxBusy
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxd_s;
  rx_state_e              state_q, state_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q, busy_d;
  logic                   tmr_clear, tmr_half, tmr_full;

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(tmr_clear),
    .half (tmr_half),
    .full (tmr_full)
  );

  assign rxd_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rxd};
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = done_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    tmr_clear = 1'b0;

    if (clrRxDone) begin
      done_d = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        tmr_clear = 1'b1;
        if (!rxd_s) state_d = START;
      end
      START: begin
        if (tmr_half) begin
          // restart the timer so every later sample lands mid-bit
          tmr_clear = 1'b1;
          if (rxd_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (tmr_full) begin
          shift_d[bit_idx_q] = rxd_s;
          if (is_last_bit(bit_idx_q)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (tmr_full) begin
          if (rxd_s) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            // a coincident clear acknowledges the previous byte, so no overrun
            if (done_q && !clrRxDone) ovr_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        tmr_clear = 1'b1;
        if (rxd_s) state_d = IDLE;
      end
      default: begin
        tmr_clear = 1'b1;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '1;
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign rxData   = data_q;
  assign rxDone   = done_q;
  assign frameErr = ferr_q;
  assign overrun  = ovr_q;
  assign rxBusy   = busy_q;

endmodule
